// File: rtl/alu4.sv
// alu4: registered 4-bit ALU with carry, signed-overflow and zero flags.
// One result per clock; inputs sampled on a rising edge show up right after it.
module alu4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] opt,
  output logic [3:0] y,
  output logic       carry,
  output logic       overflow,
  output logic       zero
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_EQ  = 3'b111
  } op_e;

  logic [4:0] sum_add;
  logic [4:0] sum_sub;
  logic       less_signed;

  logic [3:0] result_d, result_q;
  logic       carry_d, carry_q;
  logic       overflow_d, overflow_q;
  logic       zero_q;

  // Both adders run every cycle; the 5th bit of each is the carry out.
  // Signed compare is done directly on the operands so it cannot be fooled
  // by subtraction overflow at the ends of the -8..7 range.
  always_comb begin
    sum_add     = {1'b0, a} + {1'b0, b};
    sum_sub     = {1'b0, a} + {1'b0, ~b} + 5'd1;
    less_signed = $signed(a) < $signed(b);
  end

  // Select the next result and flags; only add/sub can set carry or overflow.
  always_comb begin
    result_d   = 4'b0000;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    unique case (op_e'(opt))
      OP_ADD: begin
        result_d   = sum_add[3:0];
        carry_d    = sum_add[4];
        overflow_d = (a[3] == b[3]) && (sum_add[3] != a[3]);
      end
      OP_SUB: begin
        result_d   = sum_sub[3:0];
        carry_d    = sum_sub[4];
        overflow_d = (a[3] != b[3]) && (sum_sub[3] != a[3]);
      end
      OP_NOT: result_d = ~a;
      OP_AND: result_d = a & b;
      OP_OR:  result_d = a | b;
      OP_XOR: result_d = a ^ b;
      OP_SLT: result_d = {3'b000, less_signed};
      OP_EQ:  result_d = {3'b000, (a == b)};
      default: result_d = 4'b0000;
    endcase
  end

  // Output registers; reset wins over any operation and leaves zero set to match y=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q   <= 4'b0000;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= (result_d == 4'b0000);
    end
  end

  assign y        = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu4.sv
// tb_alu4: randomized and directed checks of alu4 against an arithmetic model.
module tb_alu4;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] opt;
  logic [3:0] y;
  logic       carry;
  logic       overflow;
  logic       zero;

  int assertCount = 0;
  int failCount   = 0;
  bit seenReset   = 0;

  alu4 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .opt      (opt),
    .y        (y),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  // Returns {y, carry, overflow, zero}.
  function automatic logic [6:0] modelAlu(input logic [3:0] av, input logic [3:0] bv,
                                          input logic [2:0] op);
    int ua, ub, sa, sb, r;
    logic [3:0] yv;
    logic c, v;
    ua = int'(av);
    ub = int'(bv);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    yv = 4'd0;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      3'd0: begin
        r  = ua + ub;
        yv = 4'(r % 16);
        c  = (r >= 16);
        v  = (sa + sb > 7) || (sa + sb < -8);
      end
      3'd1: begin
        r  = ua - ub + 16;
        yv = 4'(r % 16);
        c  = (ua >= ub);
        v  = (sa - sb > 7) || (sa - sb < -8);
      end
      3'd2: yv = 4'(15 - ua);
      3'd3: yv = av & bv;
      3'd4: yv = av | bv;
      3'd5: yv = av ^ bv;
      3'd6: yv = (sa < sb) ? 4'd1 : 4'd0;
      default: yv = (ua == ub) ? 4'd1 : 4'd0;
    endcase
    return {yv, c, v, (yv == 4'd0)};
  endfunction

  // Compare one output set against expected values; one assertion per field.
  task automatic checkOutput(input string name, input logic [3:0] expY, input logic expC,
                             input logic expV, input logic expZ);
    assertCount += 4;
    if (y !== expY) begin
      failCount++;
      $display("[TB] FAIL %s y: got %b expected %b", name, y, expY);
    end
    if (carry !== expC) begin
      failCount++;
      $display("[TB] FAIL %s carry: got %b expected %b", name, carry, expC);
    end
    if (overflow !== expV) begin
      failCount++;
      $display("[TB] FAIL %s overflow: got %b expected %b", name, overflow, expV);
    end
    if (zero !== expZ) begin
      failCount++;
      $display("[TB] FAIL %s zero: got %b expected %b", name, zero, expZ);
    end
  endtask

  // Drive one set of inputs on the falling edge so they are stable at the next rising edge.
  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv,
                               input logic [2:0] op, input logic rn);
    @(negedge clk);
    a     = av;
    b     = bv;
    opt   = op;
    rst_n = rn;
  endtask

  // Wait past the capturing edge, then check against hand-computed values.
  task automatic checkLiteral(input string name, input logic [3:0] expY, input logic expC,
                              input logic expV, input logic expZ);
    @(posedge clk);
    #2;
    checkOutput(name, expY, expC, expV, expZ);
  endtask

  // Every cycle: predict from the inputs seen at the edge, check just after it.
  always @(posedge clk) begin
    logic [6:0] expVec;
    bit valid;
    if (!rst_n) begin
      expVec    = 7'b0000_001;
      seenReset = 1'b1;
    end else begin
      expVec = modelAlu(a, b, opt);
    end
    valid = seenReset;
    #1;
    if (valid)
      checkOutput("model", expVec[6:3], expVec[2], expVec[1], expVec[0]);
  end

  initial begin
    a     = 4'h0;
    b     = 4'h0;
    opt   = 3'd0;
    rst_n = 1'b1;

    // Reset with an add presented on the same edge.
    applyStimulus(4'h7, 4'h1, 3'b000, 1'b0);
    checkLiteral("reset", 4'b0000, 1'b0, 1'b0, 1'b1);

    // Add boundaries.
    applyStimulus(4'b0111, 4'b0001, 3'b000, 1'b1);
    checkLiteral("add_ovf", 4'b1000, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b1111, 4'b0001, 3'b000, 1'b1);
    checkLiteral("add_carry", 4'b0000, 1'b1, 1'b0, 1'b1);

    // Sub boundaries.
    applyStimulus(4'b0000, 4'b0001, 3'b001, 1'b1);
    checkLiteral("sub_borrow", 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1000, 4'b0001, 3'b001, 1'b1);
    checkLiteral("sub_ovf", 4'b0111, 1'b1, 1'b1, 1'b0);

    // Less-than spot checks at the range extremes.
    applyStimulus(4'b1000, 4'b0111, 3'b110, 1'b1);
    checkLiteral("slt_min_max", 4'b0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0111, 4'b1000, 3'b110, 1'b1);
    checkLiteral("slt_max_min", 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0101, 4'b0101, 3'b110, 1'b1);
    checkLiteral("slt_equal", 4'b0000, 1'b0, 1'b0, 1'b1);

    // Logic and equality with a == b.
    applyStimulus(4'b0101, 4'b0101, 3'b101, 1'b1);
    checkLiteral("xor_same", 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0101, 4'b0101, 3'b111, 1'b1);
    checkLiteral("eq_same", 4'b0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0101, 4'b0101, 3'b010, 1'b1);
    checkLiteral("not_a", 4'b1010, 1'b0, 1'b0, 1'b0);

    // Exhaustive signed less-than sweep, one pair per cycle.
    for (int sa = -8; sa <= 7; sa++)
      for (int sb = -8; sb <= 7; sb++)
        applyStimulus(4'(sa), 4'(sb), 3'b110, 1'b1);

    // Back-to-back opcode changes with fixed operands.
    for (int k = 0; k < 8; k++)
      applyStimulus(4'b0011, 4'b1010, 3'(k), 1'b1);
    checkLiteral("b2b_last_eq", 4'b0000, 1'b0, 1'b0, 1'b1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 2000; n++)
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), ($urandom_range(0, 19) != 0));

    applyStimulus(4'h0, 4'h0, 3'd0, 1'b1);
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu4.md
ALU4 -- requirements
Module: alu4

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 4 bits.
REQ-002 clk  input  1  rising-edge clock; all state SHALL update only on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; one clock; reset is synchronous and active-low.
REQ-004 a  input  4  operand A, two's complement.
REQ-005 b  input  4  operand B, two's complement.
REQ-006 opt  input  3  operation select.
REQ-007 y  output  4  registered result.
REQ-008 carry  output  1  registered carry flag.
REQ-009 overflow  output  1  registered signed-overflow flag.
REQ-010 zero  output  1  registered zero flag, 1 when the registered y equals 4'b0000.

Function
REQ-011 opt encoding SHALL be:
- 000 add: y = (a+b) mod 16.
- 001 sub: y = (a + ~b + 1) mod 16.
- 010 not: y = ~a.
- 011 and: y = a & b.
- 100 or: y = a | b.
- 101 xor: y = a ^ b.
- 110 signed less-than: y = 4'b0001 if signed(a) < signed(b), else 4'b0000.
- 111 equal: y = 4'b0001 if a == b, else 4'b0000.
REQ-012 add: carry SHALL be bit 4 of the 5-bit unsigned sum a+b; overflow SHALL be 1 iff a[3]==b[3] and y[3]!=a[3].
REQ-013 sub: carry SHALL be bit 4 of the 5-bit sum a + ~b + 1; overflow SHALL be 1 iff a[3]!=b[3] and y[3]!=a[3].
REQ-014 opt 010..111: carry and overflow SHALL be 0.
REQ-015 Signed less-than SHALL be correct over the full range -8..7, including a=-8/b=7 (result 1) and a=7/b=-8 (result 0); it SHALL NOT be derived from an overflow-prone subtraction sign alone.
REQ-016 zero SHALL be computed from the same next-state result as y, for every opt.
REQ-017 Latency: a, b and opt sampled on rising edge N SHALL appear on y/carry/overflow/zero after edge N, and SHALL remain stable until edge N+1.
REQ-018 Datapath SHALL be fully pipelined at one result per cycle, with no stalls and no handshake.
REQ-019 Undefined or X opt cannot occur; all 8 codes are defined.

Reset
REQ-020 When rst_n=0 at a rising edge, y SHALL become 4'b0000 and carry SHALL become 0 after that edge.
REQ-021 Under the same condition, overflow SHALL become 0 and zero SHALL become 1, consistent with y=0.
REQ-022 Reset SHALL take priority over any operation presented on the same edge.
REQ-023 Normal operation SHALL resume on the first rising edge with rst_n=1.
REQ-024 Outputs before the first reset edge are don't-care.

Verification
REQ-025 Reset: rst_n=0 for one edge, a=4'h7, b=4'h1, opt=000 -> y=0, carry=0, overflow=0, zero=1.
REQ-026 Add: a=0111, b=0001, opt=000 -> y=1000, overflow=1, carry=0, zero=0. Then a=1111, b=0001 -> y=0000, carry=1, overflow=0, zero=1.
REQ-027 Sub: a=0000, b=0001, opt=001 -> y=1111, carry=0, overflow=0. Then a=1000, b=0001 -> y=0111, overflow=1, carry=1.
REQ-028 Less-than: opt=110, exhaustive sweep of a,b over -8..7 (256 pairs), one per cycle; each result checked one edge later. y=0001 iff signed a<b. Spot checks: a=1000, b=0111 -> 0001; a=0111, b=1000 -> 0000; a=b -> 0000.
REQ-029 Logic/equal: a=0101, b=0101 -> opt=101 gives y=0000, zero=1; opt=111 gives y=0001, zero=0; opt=010 gives y=1010.
REQ-030 Back-to-back: change opt every cycle across all 8 codes with fixed a=0011, b=1010; each result appears exactly one edge after its inputs, with no bubbles.
